jtag_regbank: RTL and testbench

Parametrised successor to the fixed 16-channel JTAG register interface: a bank of `NUM_REGS` host-visible registers, each `WIDTH` bits wide, addressed over a serial JTAG-style scan frame. Everything runs in the `iMAIN_CLK` domain; the pins `iTCK`/`iTDI`/`iSEL` are oversampled there. The block adds addressed read/write frames, per-register write strobes, frame-abort detection and optional coherent snapshots. It sits between the board debug header and user logic.

---
 rtl/jtag_regbank_pkg.sv | 25 ++
 rtl/jtag_pin_sync.sv | 50 +++++
 rtl/jtag_regbank.sv | 233 +++++++++++++++++++++++
 tb/tb_jtag_regbank.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/jtag_regbank_pkg.sv
// jtag_regbank_pkg: shared types and constants for the JTAG-style register bank.
//   state_e      - frame FSM states
//   RW_READ/WRITE - encoding of the first bit of a frame
//   SYNC_STAGES  - synchroniser depth for the asynchronous scan pins
//   frame_len()  - total frame length in bits (R/W + address + data)
package jtag_regbank_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StData,
        StDone
    } state_e;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int unsigned SYNC_STAGES = 2;

    function automatic int unsigned frame_len(input int unsigned addr_w,
                                              input int unsigned width);
        return 1 + addr_w + width;
    endfunction

endpackage

// File: rtl/jtag_pin_sync.sv
// jtag_pin_sync: brings the asynchronous scan pins into the main clock domain.
//   clk, rst          - main clock, asynchronous active-high reset
//   tck, tdi, sel     - raw scan pins
//   tck_rise/tck_fall - one-cycle pulses on synchronised TCK edges
//   sel_rise          - one-cycle pulse on synchronised SEL rising edge
//   sel_sync/tdi_sync - synchronised pin levels, aligned with the edge pulses
module jtag_pin_sync
    import jtag_regbank_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tck,
    input  logic tdi,
    input  logic sel,
    output logic tck_rise,
    output logic tck_fall,
    output logic sel_rise,
    output logic sel_sync,
    output logic tdi_sync
);

    logic [SYNC_STAGES-1:0] tck_ff;
    logic [SYNC_STAGES-1:0] tdi_ff;
    logic [SYNC_STAGES-1:0] sel_ff;
    logic                   tck_prev;
    logic                   sel_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_ff   <= '0;
            tdi_ff   <= '0;
            sel_ff   <= '0;
            tck_prev <= 1'b0;
            sel_prev <= 1'b0;
        end else begin
            tck_ff   <= {tck_ff[SYNC_STAGES-2:0], tck};
            tdi_ff   <= {tdi_ff[SYNC_STAGES-2:0], tdi};
            sel_ff   <= {sel_ff[SYNC_STAGES-2:0], sel};
            tck_prev <= tck_ff[SYNC_STAGES-1];
            sel_prev <= sel_ff[SYNC_STAGES-1];
        end
    end

    assign tck_rise = tck_ff[SYNC_STAGES-1] & ~tck_prev;
    assign tck_fall = ~tck_ff[SYNC_STAGES-1] & tck_prev;
    assign sel_rise = sel_ff[SYNC_STAGES-1] & ~sel_prev;
    assign sel_sync = sel_ff[SYNC_STAGES-1];
    assign tdi_sync = tdi_ff[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_regbank.sv
// jtag_regbank: bank of NUM_REGS host-visible WIDTH-bit registers accessed over a
// serial JTAG-style scan frame (R/W bit, address, data; all LSB first).
//   iMAIN_CLK, iRESET  - system clock, asynchronous active-high reset
//   iTCK, iTDI, iSEL   - asynchronous scan pins, oversampled in iMAIN_CLK
//   oTDO               - scan data out (old/readback word during the data phase)
//   iDATA / oDATA      - readable / writable words, word n at [n*WIDTH +: WIDTH]
//   oWR_STB            - one-cycle per-register write strobe
//   oBUSY              - frame in progress
//   oFRAME_ERR         - one-cycle pulse when SEL drops mid-frame
//   oADDR_ERR          - one-cycle pulse on an out-of-range address
// Optional feature: define JTAG_REGBANK_SNAPSHOT_EN to latch all of iDATA at frame
// start so every read within one frame-select sees the same sample.
module jtag_regbank
    import jtag_regbank_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       NUM_REGS    = 16,
    parameter int unsigned       ADDR_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                      iMAIN_CLK,
    input  logic                      iRESET,
    input  logic                      iTCK,
    input  logic                      iTDI,
    input  logic                      iSEL,
    output logic                      oTDO,
    input  logic [NUM_REGS*WIDTH-1:0] iDATA,
    output logic [NUM_REGS*WIDTH-1:0] oDATA,
    output logic [NUM_REGS-1:0]       oWR_STB,
    output logic                      oBUSY,
    output logic                      oFRAME_ERR,
    output logic                      oADDR_ERR
);

    localparam int unsigned FRAME_LEN = frame_len(ADDR_W, WIDTH);
    localparam int unsigned CNT_W     = $clog2(WIDTH + ADDR_W + 2);

    logic tck_rise, tck_fall, sel_rise, sel_lvl, tdi_lvl;

    jtag_pin_sync u_pin_sync (
        .clk      (iMAIN_CLK),
        .rst      (iRESET),
        .tck      (iTCK),
        .tdi      (iTDI),
        .sel      (iSEL),
        .tck_rise (tck_rise),
        .tck_fall (tck_fall),
        .sel_rise (sel_rise),
        .sel_sync (sel_lvl),
        .tdi_sync (tdi_lvl)
    );

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [ADDR_W:0]             cmd_q, cmd_d;
    logic                        rw_q, rw_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic                        addr_ok_q, addr_ok_d;
    logic [WIDTH-1:0]            sr_q, sr_d;
    logic                        tdo_q, tdo_d;
    logic [NUM_REGS*WIDTH-1:0]   data_q, data_d;
    logic [NUM_REGS-1:0]         stb_q, stb_d;
    logic                        ferr_q, ferr_d;
    logic                        aerr_q, aerr_d;

    // Source of read data: live iDATA or the frame-start snapshot.
    logic [NUM_REGS*WIDTH-1:0]   rd_src;

`ifdef JTAG_REGBANK_SNAPSHOT_EN
    logic [NUM_REGS*WIDTH-1:0]   snap_q;

    always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
        if (iRESET) begin
            snap_q <= '0;
        end else if (state_q == StIdle && sel_rise) begin
            snap_q <= iDATA;
        end
    end

    assign rd_src = snap_q;
`else
    assign rd_src = iDATA;
`endif

    // Shifted versions of the command and data registers with the new TDI bit.
    logic [ADDR_W:0]   cmd_next;
    logic [WIDTH-1:0]  sr_next;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_rw;
    logic              cmd_addr_ok;
    logic [WIDTH-1:0]  rd_word;
    logic [WIDTH-1:0]  old_word;

    always_comb begin
        cmd_next         = cmd_q >> 1;
        cmd_next[ADDR_W] = tdi_lvl;
        sr_next          = sr_q >> 1;
        sr_next[WIDTH-1] = tdi_lvl;
        cmd_rw           = cmd_next[0];
        cmd_addr         = cmd_next[ADDR_W:1];
        cmd_addr_ok      = 32'(cmd_addr) < NUM_REGS;
        rd_word          = '0;
        old_word         = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (cmd_addr == ADDR_W'(i)) begin
                rd_word  = rd_src[i*WIDTH +: WIDTH];
                old_word = data_q[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        addr_ok_d = addr_ok_q;
        sr_d      = sr_q;
        tdo_d     = tdo_q;
        data_d    = data_q;
        stb_d     = '0;
        ferr_d    = 1'b0;
        aerr_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                tdo_d = 1'b0;
                if (sel_rise) begin
                    state_d = StCmd;
                    cnt_d   = '0;
                end
            end
            StCmd: begin
                if (!sel_lvl) begin
                    // Abort wins over any TCK edge in the same cycle.
                    state_d = StIdle;
                    ferr_d  = 1'b1;
                    tdo_d   = 1'b0;
                end else if (tck_rise) begin
                    cmd_d = cmd_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ADDR_W)) begin
                        rw_d      = cmd_rw;
                        addr_d    = cmd_addr;
                        addr_ok_d = cmd_addr_ok;
                        aerr_d    = !cmd_addr_ok;
                        if (!cmd_addr_ok) begin
                            sr_d = '0;
                        end else if (cmd_rw == RW_WRITE) begin
                            sr_d = old_word;
                        end else begin
                            sr_d = rd_word;
                        end
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (!sel_lvl) begin
                    state_d = StIdle;
                    ferr_d  = 1'b1;
                    tdo_d   = 1'b0;
                end else if (tck_fall) begin
                    tdo_d = sr_q[0];
                end else if (tck_rise) begin
                    sr_d  = sr_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = StDone;
                        tdo_d   = 1'b0;
                        if (rw_q == RW_WRITE && addr_ok_q) begin
                            for (int i = 0; i < int'(NUM_REGS); i++) begin
                                if (addr_q == ADDR_W'(i)) begin
                                    data_d[i*WIDTH +: WIDTH] = sr_next;
                                    stb_d[i]                 = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            StDone: begin
                tdo_d = 1'b0;
                if (!sel_lvl) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                tdo_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iMAIN_CLK or posedge iRESET) begin
        if (iRESET) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_q     <= '0;
            rw_q      <= RW_READ;
            addr_q    <= '0;
            addr_ok_q <= 1'b0;
            sr_q      <= '0;
            tdo_q     <= 1'b0;
            data_q    <= {NUM_REGS{RESET_VALUE}};
            stb_q     <= '0;
            ferr_q    <= 1'b0;
            aerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            addr_ok_q <= addr_ok_d;
            sr_q      <= sr_d;
            tdo_q     <= tdo_d;
            data_q    <= data_d;
            stb_q     <= stb_d;
            ferr_q    <= ferr_d;
            aerr_q    <= aerr_d;
        end
    end

    assign oTDO       = tdo_q;
    assign oDATA      = data_q;
    assign oWR_STB    = stb_q;
    assign oBUSY      = (state_q != StIdle);
    assign oFRAME_ERR = ferr_q;
    assign oADDR_ERR  = aerr_q;

endmodule

// File: tb/tb_jtag_regbank.sv
// tb_jtag_regbank: table-driven bench. Unit A has 16 registers, unit B has 12 (for
// out-of-range addresses). Both share TCK/TDI; each has its own SEL.
module tb_jtag_regbank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tck = 1'b0;
    logic tdi = 1'b0;
    logic sel_a = 1'b0;
    logic sel_b = 1'b0;
    logic [16*32-1:0] idata = '0;

    logic             a_tdo, a_busy, a_ferr, a_aerr;
    logic [16*32-1:0] a_odata;
    logic [15:0]      a_stb;
    logic             b_tdo, b_busy, b_ferr, b_aerr;
    logic [12*32-1:0] b_odata;
    logic [11:0]      b_stb;

    always #5 clk = ~clk;

    jtag_regbank #(.WIDTH(32), .NUM_REGS(16), .RESET_VALUE(32'h0)) u_dut_a (
        .iMAIN_CLK (clk), .iRESET (rst), .iTCK (tck), .iTDI (tdi), .iSEL (sel_a),
        .oTDO (a_tdo), .iDATA (idata), .oDATA (a_odata), .oWR_STB (a_stb),
        .oBUSY (a_busy), .oFRAME_ERR (a_ferr), .oADDR_ERR (a_aerr)
    );

    jtag_regbank #(.WIDTH(32), .NUM_REGS(12), .RESET_VALUE(32'h0)) u_dut_b (
        .iMAIN_CLK (clk), .iRESET (rst), .iTCK (tck), .iTDI (tdi), .iSEL (sel_b),
        .oTDO (b_tdo), .iDATA (idata[12*32-1:0]), .oDATA (b_odata), .oWR_STB (b_stb),
        .oBUSY (b_busy), .oFRAME_ERR (b_ferr), .oADDR_ERR (b_aerr)
    );

    // Pulse monitors: count cycles each pulse output is high, remember last strobe.
    int          stb_cnt_a = 0, aerr_cnt_a = 0, ferr_cnt_a = 0;
    int          stb_cnt_b = 0, aerr_cnt_b = 0, ferr_cnt_b = 0;
    logic [15:0] stb_last_a = '0, stb_last_b = '0;

    always @(negedge clk) begin
        if (|a_stb) begin stb_cnt_a++; stb_last_a = a_stb; end
        if (|b_stb) begin stb_cnt_b++; stb_last_b = {4'b0, b_stb}; end
        if (a_aerr) aerr_cnt_a++;
        if (a_ferr) ferr_cnt_a++;
        if (b_aerr) aerr_cnt_b++;
        if (b_ferr) ferr_cnt_b++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          tgt;      // 0 = unit A, 1 = unit B
        bit          rw;       // 1 = write
        logic [3:0]  addr;
        logic [31:0] data;
        int          ndata;    // data bits shifted before SEL drops
        logic [31:0] exp_tdo;
        logic [15:0] exp_stb;
        int          exp_aerr;
        int          exp_ferr;
    } vec_t;

    logic [16*32-1:0] model_a = '0;
    logic [12*32-1:0] model_b = '0;

    task automatic run_frame(input vec_t v, input bit keep_sel, input bit snap_hook);
        int          s0, a0, f0, sd, k;
        logic [36:0] bits;
        logic [31:0] tdo_word;
        logic [15:0] stb_act;
        s0 = v.tgt ? stb_cnt_b : stb_cnt_a;
        a0 = v.tgt ? aerr_cnt_b : aerr_cnt_a;
        f0 = v.tgt ? ferr_cnt_b : ferr_cnt_a;
        bits = {v.data, v.addr, v.rw};
        tdo_word = '0;
        @(negedge clk);
        if (v.tgt) sel_b = 1'b1; else sel_a = 1'b1;
        if (snap_hook) begin
            k = 0;
            while (!a_busy && k < 20) begin @(negedge clk); k++; end
            chk("snap_busy_seen", 512'(a_busy), 512'(1));
            idata[2*32 +: 32] = 32'h2;
        end
        repeat (6) @(negedge clk);
        for (int i = 0; i < 5 + v.ndata; i++) begin
            tdi = bits[i];
            repeat (5) @(negedge clk);
            if (i >= 5) tdo_word[i-5] = v.tgt ? b_tdo : a_tdo;
            tck = 1'b1;
            repeat (5) @(negedge clk);
            tck = 1'b0;
        end
        repeat (10) @(negedge clk);
        chk("busy_mid", 512'(v.tgt ? b_busy : a_busy), 512'(1));
        if (!keep_sel) begin
            sel_a = 1'b0;
            sel_b = 1'b0;
            repeat (10) @(negedge clk);
            chk("busy_after", 512'(v.tgt ? b_busy : a_busy), 512'(0));
        end
        if (v.ndata == 32) chk("tdo_word", 512'(tdo_word), 512'(v.exp_tdo));
        sd = (v.tgt ? stb_cnt_b : stb_cnt_a) - s0;
        stb_act = (sd > 0) ? (v.tgt ? stb_last_b : stb_last_a) : 16'h0;
        chk("wr_stb", 512'(stb_act), 512'(v.exp_stb));
        chk("wr_stb_cycles", 512'(sd), 512'((v.exp_stb != 0) ? 1 : 0));
        chk("addr_err", 512'((v.tgt ? aerr_cnt_b : aerr_cnt_a) - a0), 512'(v.exp_aerr));
        chk("frame_err", 512'((v.tgt ? ferr_cnt_b : ferr_cnt_a) - f0), 512'(v.exp_ferr));
        if (v.rw && v.ndata == 32) begin
            if (!v.tgt) model_a[v.addr*32 +: 32] = v.data;
            else if (v.addr < 12) model_b[v.addr*32 +: 32] = v.data;
        end
        chk("odata_a", 512'(a_odata), 512'(model_a));
        chk("odata_b", 512'(b_odata), 512'(model_b));
    endtask

    vec_t vecs[11];
    vec_t v;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //        tgt rw addr  data          nd  exp_tdo       exp_stb  ae fe
        vecs[0]  = '{0, 1, 3,  32'hDEADBEEF, 32, 32'h00000000, 16'h0008, 0, 0};
        vecs[1]  = '{0, 0, 5,  32'h00000000, 32, 32'h12345678, 16'h0000, 0, 0};
        vecs[2]  = '{0, 1, 3,  32'h11111111, 32, 32'hDEADBEEF, 16'h0008, 0, 0};
        vecs[3]  = '{0, 1, 15, 32'hCAFEF00D, 32, 32'h00000000, 16'h8000, 0, 0};
        vecs[4]  = '{0, 0, 0,  32'h00000000, 32, 32'hA5A50F0F, 16'h0000, 0, 0};
        vecs[5]  = '{0, 1, 1,  32'h55AA55AA, 10, 32'h00000000, 16'h0000, 0, 1};
        vecs[6]  = '{0, 1, 1,  32'h00000042, 32, 32'h00000000, 16'h0002, 0, 0};
        vecs[7]  = '{1, 1, 14, 32'hFFFFFFFF, 32, 32'h00000000, 16'h0000, 1, 0};
        vecs[8]  = '{1, 0, 13, 32'h00000000, 32, 32'h00000000, 16'h0000, 1, 0};
        vecs[9]  = '{1, 1, 11, 32'h13579BDF, 32, 32'h00000000, 16'h0800, 0, 0};
        vecs[10] = '{1, 1, 11, 32'h2468ACE0, 32, 32'h13579BDF, 16'h0800, 0, 0};

        idata[0*32 +: 32] = 32'hA5A50F0F;
        idata[5*32 +: 32] = 32'h12345678;
        idata[13*32 +: 32] = 32'h77777777;

        repeat (4) @(negedge clk);
        chk("rst_odata", 512'(a_odata), 512'(0));
        chk("rst_busy", 512'(a_busy), 512'(0));
        chk("rst_tdo", 512'(a_tdo), 512'(0));
        chk("rst_stb", 512'(a_stb), 512'(0));
        chk("rst_errs", 512'({a_ferr, a_aerr}), 512'(0));
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 11; i++) run_frame(vecs[i], 1'b0, 1'b0);

        // Reset mid-DATA: write 0xA5 to addr 0, then start another write and reset.
        v = '{0, 1, 0, 32'h000000A5, 32, 32'h00000000, 16'h0001, 0, 0};
        run_frame(v, 1'b0, 1'b0);
        v = '{0, 1, 0, 32'hFFFFFFFF, 10, 32'h00000000, 16'h0000, 0, 0};
        run_frame(v, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_odata_a", 512'(a_odata), 512'(0));
        chk("midrst_odata_b", 512'(b_odata), 512'(0));
        chk("midrst_busy", 512'(a_busy), 512'(0));
        chk("midrst_tdo", 512'(a_tdo), 512'(0));
        sel_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_no_ferr", 512'(ferr_cnt_a), 512'(1));
        rst = 1'b0;
        model_a = '0;
        model_b = '0;
        repeat (4) @(negedge clk);
        v = '{0, 1, 9, 32'h01234567, 32, 32'h00000000, 16'h0200, 0, 0};
        run_frame(v, 1'b0, 1'b0);
        v = '{0, 1, 9, 32'h89ABCDEF, 32, 32'h01234567, 16'h0200, 0, 0};
        run_frame(v, 1'b0, 1'b0);

        // iDATA[2] changes 1 -> 2 just after the frame starts.
        idata[2*32 +: 32] = 32'h1;
`ifdef JTAG_REGBANK_SNAPSHOT_EN
        v = '{0, 0, 2, 32'h00000000, 32, 32'h00000001, 16'h0000, 0, 0};
`else
        v = '{0, 0, 2, 32'h00000000, 32, 32'h00000002, 16'h0000, 0, 0};
`endif
        run_frame(v, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
